// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and
// default values for the record framing.
package prog_loader_pkg;

    // Record parser states, in frame field order:
    // SYNC, ADDR_HI, ADDR_LO, LEN, DATA x LEN, CHK
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AHI  = 3'd1,
        ST_ALO  = 3'd2,
        ST_LEN  = 3'd3,
        ST_DATA = 3'd4,
        ST_CHK  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
    localparam int         ADDR_W_DEF      = 12;
    localparam int         TIMEOUT_CYC_DEF = 100000;

    // Checksum accumulation: plain 8-bit add, wrapping mod 256.
    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-source and instruction-RAM write bus of the program loader.
//
// Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready;
// the source holds rx_data stable while rx_valid is high and not yet accepted.
// The write side has no handshake: mem_we is a one-cycle strobe qualifying
// mem_addr / mem_wdata in the same cycle.
interface prog_loader_if #(
    parameter int ADDR_W = 12
) ();
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;

    // Loader side
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_addr, mem_wdata, mem_we
    );

    // Byte source / RAM side
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/prog_loader_timeout_ctr.sv
// Inter-byte idle counter. Counts enabled cycles since the last clear and
// flags expiry in the cycle the count would reach LIMIT; a clear in that
// same cycle (an accepted byte) suppresses the expiry.
module prog_loader_timeout_ctr #(
    parameter int LIMIT = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    assign expire = en && !clr && (cnt == CW'(LIMIT - 1));

    // Idle cycle count; restarts on clear and after each expiry
    always_ff @(posedge clk) begin
        if (reset || clr || expire) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses framed records from the UART byte
// stream, writes payload bytes into instruction RAM and holds the CPU in
// reset until a valid end record (LEN=0) arrives.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W      = ADDR_W_DEF,
    parameter int         DATA_W      = 8,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          load_err,
    output state_t        dbg_state
);
    state_t              state_q;
    logic [DATA_W-1:0]   sum_q;
    logic [DATA_W-1:0]   left_q;
    logic                len_zero_q;
    logic [ADDR_W-1:0]   cur_addr_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mem_we_q;

    logic                accept;
    logic                running;
    logic                tmo_expire;
    logic [DATA_W-1:0]   sum_nx;

    // Writes are single-cycle, so the loader never needs to stall the source
    assign bus.rx_ready = 1'b1;
    assign accept       = bus.rx_valid;
    assign running      = (state_q == ST_AHI) || (state_q == ST_ALO) || (state_q == ST_LEN)
                       || (state_q == ST_DATA) || (state_q == ST_CHK);
    assign sum_nx       = sum8(sum_q, bus.rx_data);

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign dbg_state     = state_q;

    prog_loader_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept || !running),
        .en     (running),
        .expire (tmo_expire)
    );

    // Record parser FSM with running checksum, address and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sum_q       <= '0;
            left_q      <= '0;
            len_zero_q  <= 1'b0;
            cur_addr_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cpu_hold    <= 1'b1;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (tmo_expire) begin
                // Source went quiet mid-record: drop it and resync
                load_err <= 1'b1;
                state_q  <= ST_IDLE;
            end else if (accept) begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.rx_data == SYNC_BYTE) begin
                            load_err <= 1'b0;
                            sum_q    <= '0;
                            state_q  <= ST_AHI;
                        end
                    end
                    ST_AHI: begin
                        // Upper bits beyond the address width are ignored
                        sum_q                   <= sum_nx;
                        cur_addr_q[ADDR_W-1:8]  <= bus.rx_data[ADDR_W-9:0];
                        state_q                 <= ST_ALO;
                    end
                    ST_ALO: begin
                        sum_q            <= sum_nx;
                        cur_addr_q[7:0]  <= bus.rx_data;
                        state_q          <= ST_LEN;
                    end
                    ST_LEN: begin
                        sum_q      <= sum_nx;
                        left_q     <= bus.rx_data;
                        len_zero_q <= (bus.rx_data == '0);
                        state_q    <= (bus.rx_data == '0) ? ST_CHK : ST_DATA;
                    end
                    ST_DATA: begin
                        sum_q       <= sum_nx;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= bus.rx_data;
                        mem_addr_q  <= cur_addr_q;
                        cur_addr_q  <= cur_addr_q + ADDR_W'(1);
                        left_q      <= left_q - DATA_W'(1);
                        if (left_q == DATA_W'(1)) begin
                            state_q <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (sum_nx == '0) begin
                            if (len_zero_q) begin
                                cpu_hold  <= 1'b0;
                                load_done <= 1'b1;
                                state_q   <= ST_DONE;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            // Bytes already written stay written
                            load_err <= 1'b1;
                            state_q  <= ST_IDLE;
                        end
                    end
                    ST_DONE: begin
                        // Program loaded: drain and ignore everything
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: record vectors with hand-computed writes,
// checksum errors, address wrap, timeout boundary, reset mid-record and the
// end record.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int ADDR_W = 12;
    localparam int TMO    = 16;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    logic   cpu_hold;
    logic   load_done;
    logic   load_err;
    state_t dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [ADDR_W+7:0] exp_q[$];

    prog_loader_if #(.ADDR_W(ADDR_W)) bif ();

    prog_loader #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (8),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bif.slave),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] addr, input logic [7:0] data);
        exp_q.push_back({addr, data});
    endtask

    // Driver: present one byte, wait (bounded) for ready, hold through the accepting edge
    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        while (bif.rx_ready !== 1'b1 && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w == 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx_ready_wait: got %0b expected 1", bif.rx_ready);
        end
        bif.rx_data  = b;
        bif.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bif.rx_valid = 1'b0;
        bif.rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor / scoreboard: every write strobe is popped against the expected queue
    always @(negedge clk) begin
        if (bif.mem_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         bif.mem_addr, bif.mem_wdata);
            end else begin
                logic [ADDR_W+7:0] e;
                e = exp_q.pop_front();
                if ({bif.mem_addr, bif.mem_wdata} !== e) begin
                    n_err++;
                    $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                             bif.mem_addr, bif.mem_wdata, e[ADDR_W+7:8], e[7:0]);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        bif.rx_data  = 8'h00;
        bif.rx_valid = 1'b0;
        reset        = 1'b1;
        idle(3);
        check("rst_rx_ready",  bif.rx_ready,  1);
        check("rst_mem_addr",  bif.mem_addr,  0);
        check("rst_mem_wdata", bif.mem_wdata, 0);
        check("rst_mem_we",    bif.mem_we,    0);
        check("rst_cpu_hold",  cpu_hold,      1);
        check("rst_load_done", load_done,     0);
        check("rst_load_err",  load_err,      0);
        check("rst_state",     dbg_state,     ST_IDLE);
        reset = 1'b0;
        idle(1);

        // Garbage ignored, then a good 3-byte record
        send(8'h00); send(8'hFF); send(8'h3C);
        check("garbage_state", dbg_state, ST_IDLE);
        expect_wr(12'h010, 8'h11);
        expect_wr(12'h011, 8'h22);
        expect_wr(12'h012, 8'h33);
        send(8'hA5); send(8'h00); send(8'h10); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33); send(8'h87);
        check("good_err",   load_err,  0);
        check("good_hold",  cpu_hold,  1);
        check("good_done",  load_done, 0);
        check("good_state", dbg_state, ST_IDLE);

        // Bad checksum: write stays, error set
        expect_wr(12'h010, 8'h55);
        send(8'hA5); send(8'h00); send(8'h10); send(8'h01); send(8'h55); send(8'h00);
        check("badchk_err",   load_err,  1);
        check("badchk_state", dbg_state, ST_IDLE);
        check("badchk_hold",  cpu_hold,  1);

        // SYNC clears the error; address wraps 0xFFF -> 0x000; checksum 0x11 -> bad
        send(8'hA5);
        check("sync_clr_err", load_err,  0);
        check("sync_state",   dbg_state, ST_AHI);
        expect_wr(12'hFFF, 8'hAA);
        expect_wr(12'h000, 8'hBB);
        send(8'h0F); send(8'hFF); send(8'h02); send(8'hAA); send(8'hBB); send(8'h9C);
        check("wrap_err", load_err, 1);

        // ADDR_HI=0xFF treated as 0xF, good checksum
        expect_wr(12'hFFF, 8'hC3);
        send(8'hA5); send(8'hFF); send(8'hFF); send(8'h01); send(8'hC3); send(8'h3E);
        check("mask_err",   load_err,  0);
        check("mask_state", dbg_state, ST_IDLE);

        // Timeout: 15 idle cycles fine, 16th expires
        send(8'hA5); send(8'h00);
        idle(TMO - 1);
        check("tmo_pre_err",   load_err,  0);
        check("tmo_pre_state", dbg_state, ST_ALO);
        idle(1);
        check("tmo_err",   load_err,  1);
        check("tmo_state", dbg_state, ST_IDLE);

        // Byte on the exact expiry cycle wins
        send(8'hA5); send(8'h00);
        idle(TMO - 1);
        send(8'h10);
        check("tmo_edge_err",   load_err,  0);
        check("tmo_edge_state", dbg_state, ST_LEN);
        expect_wr(12'h010, 8'h55);
        send(8'h01); send(8'h55); send(8'h9A);
        check("tmo_edge_rec_err", load_err, 0);

        // Set the error, then reset in the middle of DATA
        expect_wr(12'h030, 8'h77);
        send(8'hA5); send(8'h00); send(8'h30); send(8'h01); send(8'h77); send(8'h00);
        check("pre_rst_err", load_err, 1);
        expect_wr(12'h020, 8'h11);
        send(8'hA5); send(8'h00); send(8'h20); send(8'h03); send(8'h11);
        check("mid_state", dbg_state, ST_DATA);
        reset        = 1'b1;
        bif.rx_data  = 8'h22;
        bif.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bif.rx_valid = 1'b0;
        bif.rx_data  = 8'h00;
        check("midrst_we",    bif.mem_we, 0);
        check("midrst_hold",  cpu_hold,   1);
        check("midrst_err",   load_err,   0);
        check("midrst_done",  load_done,  0);
        check("midrst_state", dbg_state,  ST_IDLE);
        reset = 1'b0;
        idle(1);

        // End record: hold drops and done rises right after CHK
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        check("end_pre_hold", cpu_hold,  1);
        check("end_pre_done", load_done, 0);
        send(8'h00);
        check("end_hold",  cpu_hold,  0);
        check("end_done",  load_done, 1);
        check("end_err",   load_err,  0);
        check("end_state", dbg_state, ST_DONE);

        // DONE drains a full record without writing
        send(8'hA5); send(8'h00); send(8'h10); send(8'h01); send(8'h55); send(8'h9A);
        idle(2);
        check("drain_state", dbg_state, ST_DONE);
        check("drain_hold",  cpu_hold,  0);
        check("drain_ready", bif.rx_ready, 1);
        check("exp_q_empty", exp_q.size(), 0);

        // Only reset leaves DONE
        reset = 1'b1;
        idle(1);
        check("final_hold",  cpu_hold,  1);
        check("final_done",  load_done, 0);
        check("final_state", dbg_state, ST_IDLE);
        reset = 1'b0;
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
